// File: rtl/som_pkg.sv
// Shared SOM definitions: codebook geometry and codebook-dump FSM states.
// Imported by the codebook write controller and its write stage.
package som_pkg;

    localparam int SOM_N_NEURONS = 64;
    localparam int SOM_DW        = 24;
    localparam int SOM_AW        = 18;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        FIN
    } cbw_state_t;

endpackage

// File: rtl/cbw_wr_stage.sv
// Registered RAM write stage: en_d1 delay, ram_we/ram_a/ram_d, word counter.
// Ports: clr (dump accepted), ser_en/ser_data_i in; ram_* , en_d1, wr_cnt out.
// Optional CB_WR_CHECKSUM_EN adds a running checksum of written words.
module cbw_wr_stage
    import som_pkg::*;
#(
    parameter int             N_WORDS   = SOM_N_NEURONS,
    parameter int             DW        = SOM_DW,
    parameter int             AW        = SOM_AW,
    parameter logic [AW-1:0]  BASE_ADDR = '0,
    parameter int             CW        = $clog2(N_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ser_en,
    input  logic [DW-1:0] ser_data_i,
    output logic          en_d1,
    output logic [CW-1:0] wr_cnt,
`ifdef CB_WR_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d1  <= 1'b0;
            ram_we <= 1'b0;
            ram_a  <= '0;
            ram_d  <= '0;
            wr_cnt <= '0;
        end else begin
            en_d1  <= ser_en;
            ram_we <= en_d1;
            // Serializer output is valid one cycle after its enable.
            if (en_d1) begin
                ram_d <= ser_data_i;
                ram_a <= BASE_ADDR + AW'(wr_cnt);
            end
            if (clr)
                wr_cnt <= '0;
            else if (en_d1)
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

`ifdef CB_WR_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            checksum <= '0;
        else if (clr)
            checksum <= '0;
        else if (en_d1)
            checksum <= checksum + ser_data_i;
    end
`endif

endmodule

// File: rtl/codebook_wr_ctrl.sv
// Codebook dump sequencer: drives serializer clr/en, writes N_WORDS to RAM.
// Ports: start/ram_ready/ser_data_i in; ser_clr, ser_en, ram_we/a/d, busy, done.
// Optional CB_WR_CHECKSUM_EN adds output checksum (sum of written words).
module codebook_wr_ctrl
    import som_pkg::*;
#(
    parameter int             N_WORDS   = SOM_N_NEURONS,
    parameter int             DW        = SOM_DW,
    parameter int             AW        = SOM_AW,
    parameter logic [AW-1:0]  BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ram_ready,
    input  logic [DW-1:0] ser_data_i,
    output logic          ser_clr,
    output logic          ser_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          busy,
`ifdef CB_WR_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    output logic          done
);

    localparam int            CW  = $clog2(N_WORDS + 1);
    localparam logic [CW-1:0] N_W = CW'(N_WORDS);

    cbw_state_t    state, nxt;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] wr_cnt;
    logic          en_d1;
    logic          start_acc;

    assign start_acc = (state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
        end else begin
            state <= nxt;
            if (start_acc)
                issue_cnt <= '0;
            else if (ser_en)
                issue_cnt <= issue_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt     = state;
        ser_clr = 1'b0;
        ser_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    nxt = CLR;
            end
            CLR: begin
                ser_clr = 1'b1;
                busy    = 1'b1;
                nxt     = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                ser_en = ram_ready && (issue_cnt < N_W);
                if (ser_en && (issue_cnt == N_W - 1'b1))
                    nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Last word is on the RAM bus once wr_cnt hits N_W.
                if ((wr_cnt == N_W) && !en_d1)
                    nxt = FIN;
            end
            FIN: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    cbw_wr_stage #(
        .N_WORDS   (N_WORDS),
        .DW        (DW),
        .AW        (AW),
        .BASE_ADDR (BASE_ADDR),
        .CW        (CW)
    ) u_wr (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .ser_en     (ser_en),
        .ser_data_i (ser_data_i),
        .en_d1      (en_d1),
        .wr_cnt     (wr_cnt),
`ifdef CB_WR_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .ram_we     (ram_we),
        .ram_a      (ram_a),
        .ram_d      (ram_d)
    );

endmodule

// File: tb/tb_codebook_wr_ctrl.sv
// Testbench for codebook_wr_ctrl: two instances (base 0 and base 3FFF0)
// fed by a table-based serializer model, with a write scoreboard.
module tb_codebook_wr_ctrl;

    localparam int            N     = 64;
    localparam logic [17:0]   BASE0 = 18'h00000;
    localparam logic [17:0]   BASE1 = 18'h3FFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ram_ready = 1'b1;
    logic [1:0]  ser_clr, ser_en, ram_we, busy, done;
    logic [17:0] ram_a [2];
    logic [23:0] ram_d [2];
    logic [23:0] sd [2];
    logic [5:0]  idx [2];
    logic [23:0] w [N];
`ifdef CB_WR_CHECKSUM_EN
    logic [23:0] cs [2];
`endif

    int wcnt [2];
    int en_cnt [2];
    int done_cnt [2];
    int checks = 0;
    int errors = 0;
    logic [17:0] ea;

    typedef struct {
        int          cyc;
        logic        clr;
        logic        en;
        logic        we;
        logic [17:0] a;
        logic [23:0] d;
        logic        b;
        logic        dn;
    } vec_t;

    vec_t tab [11];
    int   cyc;

    always #5 clk = ~clk;

    codebook_wr_ctrl #(
        .N_WORDS(64), .DW(24), .AW(18), .BASE_ADDR(BASE0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .ram_ready(ram_ready),
        .ser_data_i(sd[0]), .ser_clr(ser_clr[0]), .ser_en(ser_en[0]),
        .ram_we(ram_we[0]), .ram_a(ram_a[0]), .ram_d(ram_d[0]),
        .busy(busy[0]),
`ifdef CB_WR_CHECKSUM_EN
        .checksum(cs[0]),
`endif
        .done(done[0])
    );

    codebook_wr_ctrl #(
        .N_WORDS(64), .DW(24), .AW(18), .BASE_ADDR(BASE1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .ram_ready(ram_ready),
        .ser_data_i(sd[1]), .ser_clr(ser_clr[1]), .ser_en(ser_en[1]),
        .ram_we(ram_we[1]), .ram_a(ram_a[1]), .ram_d(ram_d[1]),
        .busy(busy[1]),
`ifdef CB_WR_CHECKSUM_EN
        .checksum(cs[1]),
`endif
        .done(done[1])
    );

    // Serializer model: registered word output, index cleared by ser_clr.
    always @(posedge clk or posedge rst) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                idx[j] <= '0;
                sd[j]  <= '0;
            end else if (ser_clr[j]) begin
                idx[j] <= '0;
            end else if (ser_en[j]) begin
                sd[j]  <= w[idx[j]];
                idx[j] <= idx[j] + 6'd1;
            end
        end
    end

    // Write scoreboard: word k must land at base+k with data w[k].
    always @(posedge clk) begin
        #3;
        for (int j = 0; j < 2; j++) begin
            if (ram_we[j]) begin
                checks++;
                if (wcnt[j] >= N) begin
                    errors++;
                    $display("FAIL extra_write dut%0d a=%h count=%0d limit=%0d",
                             j, ram_a[j], wcnt[j] + 1, N);
                end else begin
                    ea = ((j == 0) ? BASE0 : BASE1) + 18'(wcnt[j]);
                    if (ram_a[j] !== ea || ram_d[j] !== w[wcnt[j]]) begin
                        errors++;
                        $display("FAIL write dut%0d k=%0d a=%h d=%h expected a=%h d=%h",
                                 j, wcnt[j], ram_a[j], ram_d[j], ea, w[wcnt[j]]);
                    end
                end
                wcnt[j]++;
            end
            if (ser_en[j]) begin
                en_cnt[j]++;
                checks++;
                if (!ram_ready) begin
                    errors++;
                    $display("FAIL ser_en_while_throttled dut%0d actual=1 expected=0", j);
                end
            end
            if (done[j])
                done_cnt[j]++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        for (int j = 0; j < 2; j++) begin
            wcnt[j]     = 0;
            en_cnt[j]   = 0;
            done_cnt[j] = 0;
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("%s_ctl%0d", nm, j),
                64'({ser_clr[j], ser_en[j], ram_we[j], busy[j], done[j]}), 64'd0);
            chk($sformatf("%s_a%0d", nm, j), 64'(ram_a[j]), 64'd0);
            chk($sformatf("%s_d%0d", nm, j), 64'(ram_d[j]), 64'd0);
        end
    endtask

`ifdef CB_WR_CHECKSUM_EN
    function automatic logic [23:0] wsum();
        logic [23:0] s = '0;
        for (int k = 0; k < N; k++)
            s = s + w[k];
        return s;
    endfunction
`endif

    // One dump. thr/ign/abt: issue index at which to throttle, pulse start,
    // or reset (-1 = never). chain starts the next dump right after done;
    // pre means start was already raised by a chained predecessor.
    task automatic do_dump(input int thr, input int ign, input int abt,
                           input bit chain, input bit pre);
        int iss = 0;
        int low = 0;
        bit seen = 0;
        bit bbad = 0;
        bit tf = 0;
        bit igf = 0;
        clr_mon();
        if (!pre) begin
            tick();
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick();
            if (low > 0) begin
                low--;
                if (low == 0)
                    ram_ready = 1'b1;
            end
            if (thr >= 0 && !tf && iss == thr + 1) begin
                tf = 1;
                ram_ready = 1'b0;
                low = 5;
            end
            if (ign >= 0 && !igf && iss == ign + 1) begin
                igf = 1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (abt >= 0 && iss == abt + 1) begin
                rst = 1'b1;
                #1;
                chk_zero("reset_mid");
                tick();
                rst = 1'b0;
                repeat (4) tick();
                chk("abort_no_done", 64'(done_cnt[0] + done_cnt[1]), 64'd0);
                chk("abort_idle", 64'({busy, ram_we}), 64'd0);
                return;
            end
            #1;
            if (done[0])
                seen = 1;
            else if (!busy[0])
                bbad = 1;
            iss += int'(ser_en[0]);
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("writes0", 64'(wcnt[0]), 64'(N));
        chk("writes1", 64'(wcnt[1]), 64'(N));
        chk("issues", 64'(en_cnt[0]), 64'(N));
        chk("busy_low_at_done", 64'(busy), 64'd0);
        chk("busy_continuous", 64'(bbad), 64'd0);
`ifdef CB_WR_CHECKSUM_EN
        chk("checksum0", 64'(cs[0]), 64'(wsum()));
        chk("checksum1", 64'(cs[1]), 64'(wsum()));
`endif
        tick();
        #1;
        chk("single_done0", 64'(done_cnt[0]), 64'd1);
        chk("single_done1", 64'(done_cnt[1]), 64'd1);
        chk("done_one_cycle", 64'(done), 64'd0);
        if (chain)
            start = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++)
            w[k] = 24'h0A0000 + 24'(k);
        clr_mon();

        tab[0]  = '{0,  0, 0, 0, 18'd0,  24'h000000, 0, 0};
        tab[1]  = '{1,  1, 0, 0, 18'd0,  24'h000000, 1, 0};
        tab[2]  = '{2,  0, 1, 0, 18'd0,  24'h000000, 1, 0};
        tab[3]  = '{3,  0, 1, 0, 18'd0,  24'h000000, 1, 0};
        tab[4]  = '{4,  0, 1, 1, 18'd0,  24'h0A0000, 1, 0};
        tab[5]  = '{5,  0, 1, 1, 18'd1,  24'h0A0001, 1, 0};
        tab[6]  = '{65, 0, 1, 1, 18'd61, 24'h0A003D, 1, 0};
        tab[7]  = '{66, 0, 0, 1, 18'd62, 24'h0A003E, 1, 0};
        tab[8]  = '{67, 0, 0, 1, 18'd63, 24'h0A003F, 1, 0};
        tab[9]  = '{68, 0, 0, 0, 18'd63, 24'h0A003F, 0, 1};
        tab[10] = '{69, 0, 0, 0, 18'd63, 24'h0A003F, 0, 0};

        #2;
        chk_zero("reset");
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk_zero("idle");

        // Basic dump, cycle-accurate against the vector table.
        clr_mon();
        tick();
        start = 1'b1;
        cyc = 0;
        #1;
        for (int i = 0; i < 11; i++) begin
            while (cyc < tab[i].cyc) begin
                tick();
                cyc++;
                if (cyc == 1)
                    start = 1'b0;
                #1;
            end
            chk($sformatf("vec_cyc%0d", tab[i].cyc),
                64'({ser_clr[0], ser_en[0], ram_we[0], busy[0], done[0],
                     ram_a[0], ram_d[0]}),
                64'({tab[i].clr, tab[i].en, tab[i].we, tab[i].b, tab[i].dn,
                     tab[i].a, tab[i].d}));
        end
        chk("basic_writes", 64'(wcnt[0]), 64'(N));
        chk("basic_done_cnt", 64'(done_cnt[0]), 64'd1);
        chk("basic_en_cnt", 64'(en_cnt[0]), 64'(N));

        do_dump(10, -1, -1, 1'b0, 1'b0);
        do_dump(-1, 30, -1, 1'b0, 1'b0);
        do_dump(-1, -1, 20, 1'b0, 1'b0);
        do_dump(-1, -1, -1, 1'b0, 1'b0);
        do_dump(-1, -1, -1, 1'b1, 1'b0);
        do_dump(-1, -1, -1, 1'b0, 1'b1);

`ifdef CB_WR_CHECKSUM_EN
        for (int k = 0; k < N; k++)
            w[k] = 24'(k + 1);
        do_dump(-1, -1, -1, 1'b0, 1'b0);
        chk("checksum_2080", 64'(cs[0]), 64'd2080);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codebook_wr_ctrl.md
Name: codebook_wr_ctrl

Overview:
- Sequencer that dumps the trained 64-neuron SOM codebook into external weight RAM.
- Sits between the top-level SOM controller (start/done) and the word serializer, which converts 64×24-bit weights into one 24-bit word per enable.
- Generates serializer clear/enable pulses, RAM address, write-enable and registered write data.
- Honours a RAM throttle signal and reports busy/done.

Parameters:
- N_WORDS, 64, number of codebook words per dump (1..4096)
- DW, 24, word width
- AW, 18, RAM address width
- BASE_ADDR, 18'd0, RAM address of word 0

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle dump request, sampled in IDLE only
- ram_ready  in  1  RAM can accept a new word issue this cycle
- ser_data_i  in  DW  serializer registered output word
- ser_clr  out  1  one-cycle serializer index clear (index back to word 0)
- ser_en  out  1  serializer shift-enable, one word per pulse
- ram_we  out  1  RAM write enable
- ram_a  out  AW  RAM write address
- ram_d  out  DW  RAM write data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last RAM write

Behaviour:
- Reset: all outputs 0; state IDLE; issue_cnt = 0; wr_cnt = 0; pipeline valid bits cleared. Reset is legal mid-dump and aborts the dump with no done pulse. The serializer shares rst.
- FSM states: IDLE, CLR, RUN, DRAIN, FIN.
- IDLE:
  - start=1 goes to CLR, busy rises next cycle, issue_cnt and wr_cnt cleared.
  - start in any other state is ignored.
- CLR: ser_clr=1 for exactly one cycle, then RUN.
- RUN:
  - ser_en = ram_ready && (issue_cnt < N_WORDS), combinational from registered state; issue_cnt increments on each ser_en.
  - When issue_cnt reaches N_WORDS, go to DRAIN.
  - ram_ready low simply holds issue with no loss.
- Datapath, latency 2:
  - en_d1 <= ser_en.
  - In the cycle after ser_en, ser_data_i holds the new word.
  - On that edge: ram_we <= en_d1; ram_d <= ser_data_i; ram_a <= BASE_ADDR + wr_cnt. wr_cnt increments when en_d1=1.
  - Result: ram_we appears 2 cycles after its ser_en.
  - ram_a wraps modulo 2^AW.
  - ram_d and ram_a hold their last values when ram_we=0.
- RAM contract: the RAM accepts every ram_we pulse. ram_ready throttles issue only; up to 2 words in flight complete after ram_ready drops.
- DRAIN: wait until wr_cnt == N_WORDS and no pipeline valid bit is set, then FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Ordering: word k goes to address BASE_ADDR+k. Word 0 is w0, the most significant slice of the serializer's concatenation.
- Back-to-back dumps: start in the cycle after done is accepted. CLR re-aligns the serializer, so dumps are always word-0-first.

Optional Feature:
- Macro: CB_WR_CHECKSUM_EN.
- With it:
  - Extra output checksum[DW-1:0] = sum modulo 2^DW of all ram_d values written in the dump.
  - Cleared to 0 on start acceptance; accumulates on each ram_we.
  - Valid and stable from the done cycle until the next start. Reset value 0.
- Without it: no port and no adder; behaviour otherwise identical.

Decomposition:
- Shared package som_pkg holds:
  - constants SOM_N_NEURONS=64, SOM_DW=24, SOM_AW=18;
  - enum cbw_state_t {IDLE, CLR, RUN, DRAIN, FIN}.
- One natural sub-module, cbw_wr_stage: the 1-cycle registered write stage (ram_we/ram_a/ram_d/wr_cnt, plus the checksum when enabled). The FSM and issue counter stay in the top module.

Test Plan:
- Basic dump: rst then start, ram_ready=1, serializer model loaded with w_k=24'h0A0000+k, BASE_ADDR=0.
  - ser_clr in cycle 1 after start.
  - 64 consecutive ser_en.
  - First ram_we 2 cycles after first ser_en: a=0, d=24'h0A0000.
  - Last write a=63, d=24'h0A003F.
  - done exactly once, 1 cycle after the last ram_we.
- Throttle: ram_ready low for 5 cycles after word 10 issued.
  - Words 10..11 still written.
  - No ser_en while low.
  - Addresses contiguous, 64 writes total, no duplicates.
- Ignore start: pulse start at word 30.
  - Exactly 64 writes; single done; busy continuous.
- Reset mid-op: rst at word 20.
  - All outputs 0 within the same cycle; no done.
  - Fresh start yields a full 64-word dump beginning at word 0.
- Back-to-back dumps with BASE_ADDR=18'h3FFF0: second start the cycle after done.
  - Address wraps 3FFFF→00000.
  - Second dump data identical to the first.
- CB_WR_CHECKSUM_EN with w_k=k+1: checksum=24'd2080 at done.
